sdram_port_arbiter: RTL and testbench

- Two-requester arbiter sharing the single SDRAM core RAM request port (wr/rd/len/addr/write_data/accept/ack/error/read_data) between the AXI slave front end and a second master (e.g. DMA/video fetch).
- Sits between requesters and sdram_axi_core; each requester sees an identical RAM port.
- Round-robin grant with burst lock; in-order ID tracking routes each ack/read data back to its owner.

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_arb_id_fifo.sv | 67 ++++++
 rtl/sdram_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM request arbiter: port IDs, FSM states
// and the default depth of the in-flight ID FIFO.
package sdram_arb_pkg;

  localparam int NUM_PORTS               = 2;
  localparam int DEFAULT_MAX_OUTSTANDING = 4;

  typedef logic port_id_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic port_id_t other_port(input port_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// In-order FIFO of requester IDs for requests the core has accepted but not
// yet acknowledged. DEPTH must be a power of two so the pointers wrap freely.
module sdram_arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  port_id_t push_id_i,
  input  logic     pop_i,
  output port_id_t head_id_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  port_id_t         mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);

  // Guard both sides so a stray push when full or pop when empty cannot corrupt state.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

  assign head_id_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM core request port between two requesters with round-robin
// grant and burst lock. Define SDRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [3:0]            p0_wr_i,
  input  logic                  p0_rd_i,
  input  logic [7:0]            p0_len_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_write_data_i,
  output logic                  p0_accept_o,
  output logic                  p0_ack_o,
  output logic                  p0_error_o,
  output logic [DATA_WIDTH-1:0] p0_read_data_o,

  input  logic [3:0]            p1_wr_i,
  input  logic                  p1_rd_i,
  input  logic [7:0]            p1_len_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_write_data_i,
  output logic                  p1_accept_o,
  output logic                  p1_ack_o,
  output logic                  p1_error_o,
  output logic [DATA_WIDTH-1:0] p1_read_data_o,

  output logic [3:0]            ram_wr_o,
  output logic                  ram_rd_o,
  output logic [7:0]            ram_len_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_write_data_o,
  input  logic                  ram_accept_i,
  input  logic                  ram_ack_i,
  input  logic                  ram_error_i,
  input  logic [DATA_WIDTH-1:0] ram_read_data_i,

  output logic                  spurious_ack_o
);

  logic [3:0]            wr_a    [NUM_PORTS];
  logic                  rd_a    [NUM_PORTS];
  logic [7:0]            len_a   [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];

  logic [NUM_PORTS-1:0] valid;
  logic [NUM_PORTS-1:0] accept_vec;
  logic [NUM_PORTS-1:0] ack_vec;
  logic [NUM_PORTS-1:0] err_vec;

  arb_state_e state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  port_id_t   last_grant_q, last_grant_d;
  logic       spurious_q, spurious_d;

  port_id_t sel;
  logic     req_gate;
  logic     push;
  logic     pop;
  logic     resp_valid;
  port_id_t head_id;
  logic     fifo_full;
  logic     fifo_empty;

  assign wr_a[0]    = p0_wr_i;
  assign rd_a[0]    = p0_rd_i;
  assign len_a[0]   = p0_len_i;
  assign addr_a[0]  = p0_addr_i;
  assign wdata_a[0] = p0_write_data_i;
  assign wr_a[1]    = p1_wr_i;
  assign rd_a[1]    = p1_rd_i;
  assign len_a[1]   = p1_len_i;
  assign addr_a[1]  = p1_addr_i;
  assign wdata_a[1] = p1_write_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign valid[gi]      = rd_a[gi] | (|wr_a[gi]);
      assign accept_vec[gi] = ram_accept_i & ~rst_i & ~fifo_full & valid[gi]
                              & (sel == port_id_t'(gi));
      assign ack_vec[gi]    = resp_valid & (head_id == port_id_t'(gi));
      assign err_vec[gi]    = ack_vec[gi] & ram_error_i;
    end
  endgenerate

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      burst_cnt_q  <= '0;
      last_grant_q <= 1'b1;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_grant_q <= last_grant_d;
      spurious_q   <= spurious_d;
    end
  end

  // Next state: the first beat of a multi-beat burst locks the port; later beats' len is ignored.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_grant_d = last_grant_q;
    if (push) begin
      last_grant_d = sel;
      case (state_q)
        ARB_IDLE: begin
          if (ram_len_o != '0) begin
            state_d     = ARB_LOCKED;
            burst_cnt_d = ram_len_o;
          end
        end
        ARB_LOCKED: begin
          burst_cnt_d = burst_cnt_q - 8'd1;
          if (burst_cnt_q == 8'd1) state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
    spurious_d = spurious_q | (ram_ack_i & fifo_empty);
  end

  // Outputs: port selection and the zero-latency request mux.
  always_comb begin
    sel = 1'b0;
    if (state_q == ARB_LOCKED) begin
      // last_grant doubles as the lock owner, since the locking beat just set it.
      sel = last_grant_q;
    end else if (valid[0] && valid[1]) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = other_port(last_grant_q);
`endif
    end else if (valid[1]) begin
      sel = 1'b1;
    end
    req_gate         = ~rst_i & ~fifo_full;
    ram_rd_o         = rd_a[sel] & req_gate;
    ram_wr_o         = req_gate ? wr_a[sel] : 4'b0;
    ram_len_o        = len_a[sel];
    ram_addr_o       = addr_a[sel];
    ram_write_data_o = wdata_a[sel];
  end

  assign push       = ram_accept_i & (ram_rd_o | (|ram_wr_o));
  assign pop        = ram_ack_i & ~fifo_empty;
  assign resp_valid = pop & ~rst_i;

  sdram_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .push_id_i (sel),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign p0_accept_o    = accept_vec[0];
  assign p1_accept_o    = accept_vec[1];
  assign p0_ack_o       = ack_vec[0];
  assign p1_ack_o       = ack_vec[1];
  assign p0_error_o     = err_vec[0];
  assign p1_error_o     = err_vec[1];
  assign p0_read_data_o = ram_read_data_i;
  assign p1_read_data_o = ram_read_data_i;
  assign spurious_ack_o = spurious_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a queue-based model of grants, bursts and
// in-order responses is checked against the DUT every cycle, plus literal pins.
module tb_sdram_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [3:0]    p0_wr_i, p1_wr_i;
  logic          p0_rd_i, p1_rd_i;
  logic [7:0]    p0_len_i, p1_len_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [DW-1:0] p0_write_data_i, p1_write_data_i;
  logic          p0_accept_o, p1_accept_o, p0_ack_o, p1_ack_o, p0_error_o, p1_error_o;
  logic [DW-1:0] p0_read_data_o, p1_read_data_o;
  logic [3:0]    ram_wr_o;
  logic          ram_rd_o;
  logic [7:0]    ram_len_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_write_data_o;
  logic          ram_accept_i, ram_ack_i, ram_error_i;
  logic [DW-1:0] ram_read_data_i;
  logic          spurious_ack_o;

  always #5 clk_i = ~clk_i;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_wr_i(p0_wr_i), .p0_rd_i(p0_rd_i), .p0_len_i(p0_len_i), .p0_addr_i(p0_addr_i),
    .p0_write_data_i(p0_write_data_i), .p0_accept_o(p0_accept_o), .p0_ack_o(p0_ack_o),
    .p0_error_o(p0_error_o), .p0_read_data_o(p0_read_data_o),
    .p1_wr_i(p1_wr_i), .p1_rd_i(p1_rd_i), .p1_len_i(p1_len_i), .p1_addr_i(p1_addr_i),
    .p1_write_data_i(p1_write_data_i), .p1_accept_o(p1_accept_o), .p1_ack_o(p1_ack_o),
    .p1_error_o(p1_error_o), .p1_read_data_o(p1_read_data_o),
    .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_len_o(ram_len_o), .ram_addr_o(ram_addr_o),
    .ram_write_data_o(ram_write_data_o), .ram_accept_i(ram_accept_i), .ram_ack_i(ram_ack_i),
    .ram_error_i(ram_error_i), .ram_read_data_i(ram_read_data_i),
    .spurious_ack_o(spurious_ack_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the arbiter holds after the next rising edge.
  int  m_last      = 1;
  bit  m_locked    = 0;
  int  m_lock_port = 0;
  int  m_remaining = 0;
  int  m_q[$];
  bit  m_spur      = 0;

  int          grant_log[$];
  int          ack_port_log[$];
  logic [31:0] ack_data_log[$];
  bit          ack_err_log[$];

  bit          auto_ack = 0;
  logic [31:0] auto_data = 32'hD000_0000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Compare process: expected outputs from current inputs and model state, then advance the model.
  always @(negedge clk_i) begin
    logic [3:0]  wr  [2];
    logic        rd  [2];
    logic [7:0]  len [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wd [2];
    bit          v [2];
    int          sel, h;
    bit          full, popped;
    logic [1:0]  e_acc, e_ack, e_err;
    logic        e_rd;
    logic [3:0]  e_wr;

    wr[0] = p0_wr_i;  rd[0] = p0_rd_i;  len[0] = p0_len_i;  adr[0] = p0_addr_i;  wd[0] = p0_write_data_i;
    wr[1] = p1_wr_i;  rd[1] = p1_rd_i;  len[1] = p1_len_i;  adr[1] = p1_addr_i;  wd[1] = p1_write_data_i;
    v[0] = rd[0] || (wr[0] != 0);
    v[1] = rd[1] || (wr[1] != 0);

    check("spurious", spurious_ack_o, m_spur);
    if (rst_i) begin
      check("rst_accepts", {p1_accept_o, p0_accept_o}, 2'b00);
      check("rst_acks",    {p1_ack_o, p0_ack_o}, 2'b00);
      check("rst_errors",  {p1_error_o, p0_error_o}, 2'b00);
      check("rst_ram_req", {ram_rd_o, ram_wr_o}, 5'b0);
      m_last = 1; m_locked = 0; m_lock_port = 0; m_remaining = 0;
      m_q.delete(); m_spur = 0;
    end else begin
      if (m_locked) sel = m_lock_port;
      else if (v[0] && v[1]) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        sel = 0;
`else
        sel = 1 - m_last;
`endif
      end else sel = v[1] ? 1 : 0;

      full  = (m_q.size() == MAXO);
      e_rd  = full ? 1'b0 : rd[sel];
      e_wr  = full ? 4'b0 : wr[sel];
      e_acc = 2'b00;
      if (ram_accept_i && v[sel] && !full) e_acc[sel] = 1'b1;
      e_ack = 2'b00;
      e_err = 2'b00;
      h = -1;
      if (ram_ack_i && m_q.size() > 0) begin
        h = m_q[0];
        e_ack[h] = 1'b1;
        e_err[h] = ram_error_i;
      end

      check("accepts", {p1_accept_o, p0_accept_o}, e_acc);
      check("acks",    {p1_ack_o, p0_ack_o}, e_ack);
      check("errors",  {p1_error_o, p0_error_o}, e_err);
      check("ram_rdwr", {ram_rd_o, ram_wr_o}, {e_rd, e_wr});
      if (e_rd || e_wr != 0)
        check("ram_fields", {ram_len_o, ram_addr_o, ram_write_data_o}, {len[sel], adr[sel], wd[sel]});
      if (h >= 0)
        check("read_data", (h == 0) ? p0_read_data_o : p1_read_data_o, ram_read_data_i);

      popped = (h >= 0);
      if (ram_ack_i && !popped) m_spur = 1;
      if (popped) begin
        $display("ack   port %0d data %08h err %0d", h, ram_read_data_i, ram_error_i);
        ack_port_log.push_back(h);
        ack_data_log.push_back(ram_read_data_i);
        ack_err_log.push_back(ram_error_i);
        void'(m_q.pop_front());
      end
      if (e_acc != 0) begin
        $display("grant port %0d addr %08h len %0d", sel, adr[sel], len[sel]);
        grant_log.push_back(sel);
        m_q.push_back(sel);
        m_last = sel;
        if (!m_locked) begin
          if (len[sel] != 0) begin
            m_locked = 1; m_lock_port = sel; m_remaining = len[sel];
          end
        end else begin
          m_remaining--;
          if (m_remaining == 0) m_locked = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (auto_ack) begin
      ram_ack_i       = (m_q.size() > 0);
      ram_error_i     = 1'b0;
      auto_data       = auto_data + 1;
      ram_read_data_i = auto_data;
    end
  endtask

  task automatic idle_ports();
    p0_rd_i = 0; p0_wr_i = 0; p0_len_i = 0;
    p1_rd_i = 0; p1_wr_i = 0; p1_len_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int exp_t1[4];
  int exp_t2[6];
  int exp_t6[2];

  initial begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_t1 = '{0, 0, 0, 0};
    exp_t2 = '{0, 0, 0, 0, 0, 0};
    exp_t6 = '{0, 0};
`else
    exp_t1 = '{0, 1, 0, 1};
    exp_t2 = '{0, 1, 1, 1, 1, 0};
    exp_t6 = '{0, 1};
`endif
    rst_i = 1; idle_ports();
    p0_addr_i = 32'h1000_0000; p0_write_data_i = 32'h0000_00A0;
    p1_addr_i = 32'h2000_0000; p1_write_data_i = 32'h0000_00B1;
    ram_accept_i = 1; ram_ack_i = 0; ram_error_i = 0; ram_read_data_i = 0;

    // Reset with a live request: nothing may be accepted.
    p0_rd_i = 1;
    repeat (3) tick();
    check("reset_spurious", spurious_ack_o, 1'b0);
    rst_i = 0;

    // T1: both read single beats; FIFO fills after four, then stalls.
    p0_rd_i = 1; p1_rd_i = 1;
    repeat (6) tick();
    check("t1_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_grant%0d", i), qget(grant_log, i), exp_t1[i]);
    idle_ports();
    for (int i = 1; i <= 4; i++) begin
      ram_ack_i = 1; ram_read_data_i = 32'hA5A5_0000 + i;
      tick();
    end
    ram_ack_i = 0;
    check("t1_ack_count", ack_port_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_ackport%0d", i), qget(ack_port_log, i), exp_t1[i]);
    check("t1_ackdata0", ack_data_log[0], 32'hA5A5_0001);
    check("t1_ackdata1", ack_data_log[1], 32'hA5A5_0002);

    // T2: port 1 len=3 burst locks out port 0 for four beats.
    grant_log.delete();
    auto_ack = 1;
    p0_rd_i = 1;
    tick();
    p1_rd_i = 1; p1_len_i = 8'd3;
    tick();
    p1_len_i = 8'd9;
    repeat (4) tick();
    idle_ports();
    check("t2_count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t2_grant%0d", i), qget(grant_log, i), exp_t2[i]);
    for (int i = 0; i < 10 && m_q.size() > 0; i++) tick();
    auto_ack = 0; ram_ack_i = 0;
    tick();

    // T4: error response on a port-1 write.
    ack_port_log.delete(); ack_err_log.delete();
    p1_wr_i = 4'hF; p1_addr_i = 32'h2000_0040; p1_write_data_i = 32'hCAFE_0001;
    tick();
    idle_ports();
    ram_ack_i = 1; ram_error_i = 1; ram_read_data_i = 32'h0;
    tick();
    ram_ack_i = 0; ram_error_i = 0;
    check("t4_ack_port", qget(ack_port_log, 0), 1);
    check("t4_ack_err", (ack_err_log.size() > 0) ? ack_err_log[0] : 1'b0, 1'b1);

    // T5: ack with empty FIFO sets the sticky flag.
    ack_port_log.delete();
    ram_ack_i = 1;
    tick();
    ram_ack_i = 0;
    repeat (2) tick();
    check("t5_no_route", ack_port_log.size(), 0);
    check("t5_spurious_sticky", spurious_ack_o, 1'b1);

    // T6: reset in the middle of a port-0 len=7 burst.
    grant_log.delete();
    auto_ack = 1;
    p0_rd_i = 1; p0_len_i = 8'd7; p1_rd_i = 1;
    repeat (3) tick();
    check("t6_locked_count", grant_log.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t6_lock%0d", i), qget(grant_log, i), 0);
    rst_i = 1;
    tick();
    rst_i = 0; p0_len_i = 8'd0;
    check("t6_spurious_cleared", spurious_ack_o, 1'b0);
    grant_log.delete();
    ram_accept_i = 0;
    tick();
    ram_accept_i = 1;
    repeat (2) tick();
    check("t6_count", grant_log.size(), 2);
    for (int i = 0; i < 2; i++) check($sformatf("t6_grant%0d", i), qget(grant_log, i), exp_t6[i]);
    idle_ports();
    for (int i = 0; i < 10 && m_q.size() > 0; i++) tick();
    auto_ack = 0; ram_ack_i = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
